// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the issue-controller state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_NOR    = 4'h5;
  localparam logic [3:0] ALU_SLT    = 4'h6;
  localparam logic [3:0] ALU_SLL    = 4'h7;
  localparam logic [3:0] ALU_SRL    = 4'h8;
  localparam logic [3:0] ALU_OP_MAX = 4'h8;

  // Bit positions inside the {N,V,C,Z} flag vector.
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAP_R = 3'd2,
    ST_CAP_F = 3'd3,
    ST_RESP  = 3'd4
  } alu_state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator for the registered ALU: issues one op, waits out result and flag latency,
// and returns result/flags/tag on a valid/ready response port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_illegal,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output alu_state_e        dbg_state
);

  // Both ports follow the same rule: a transfer happens on a rising clk edge where
  // valid && ready; the initiator holds valid and its payload stable until then.

  alu_state_e        state_q, state_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              illegal_q, illegal_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic req_accept;
  logic req_is_illegal;
  logic op_has_cv;

  assign req_ready      = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign req_accept     = req_valid && req_ready;
  assign req_is_illegal = req_op > OP_W'(ALU_OP_MAX);
  // Only ADD/SUB refresh the ALU's carry/overflow; other ops leave stale values there.
  assign op_has_cv      = (alu_op_q == OP_W'(ALU_ADD)) || (alu_op_q == OP_W'(ALU_SUB));

  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    tag_d         = tag_q;
    illegal_d     = illegal_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_tag_d     = rsp_tag_q;
    op_count_d    = op_count_q;

    case (state_q)
      ST_ISSUE: begin
        // An illegal op spends its single cycle here and never waits on the ALU.
        if (illegal_q) begin
          rsp_result_d  = '0;
          rsp_flags_d   = '0;
          rsp_illegal_d = 1'b1;
          rsp_tag_d     = tag_q;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          state_d = ST_CAP_R;
        end
      end
      ST_CAP_R: begin
        rsp_result_d        = alu_result;
        rsp_flags_d         = '0;
        rsp_flags_d[FLG_C]  = op_has_cv && alu_carry;
        rsp_flags_d[FLG_V]  = op_has_cv && alu_overflow;
        state_d             = ST_CAP_F;
      end
      ST_CAP_F: begin
        rsp_flags_d[FLG_Z] = alu_zero;
        rsp_flags_d[FLG_N] = alu_negative;
        rsp_illegal_d      = 1'b0;
        rsp_tag_d          = tag_q;
        rsp_valid_d        = 1'b1;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (req_accept) begin
      alu_op_d  = req_op;
      alu_a_d   = req_a;
      alu_b_d   = req_b;
      tag_d     = req_tag;
      illegal_d = req_is_illegal;
      state_d   = ST_ISSUE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      alu_op_q      <= OP_W'(ALU_ADD);
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      tag_q         <= '0;
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_tag_q     <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      tag_q         <= tag_d;
      illegal_q     <= illegal_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_tag_q     <= rsp_tag_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_tag     = rsp_tag_q;
  assign busy        = (state_q != ST_IDLE);
  assign op_count    = op_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural registered ALU as its partner
// (Result/C/V one edge after inputs, Z/N one edge after Result).
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int EXP_W  = TAG_W + 1 + 4 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- DUT ----------------
  logic              req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]        req_op, alu_op;
  logic [DATA_W-1:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [TAG_W-1:0]  req_tag, rsp_tag;
  logic              alu_zero, alu_carry, alu_overflow, alu_negative;
  logic [3:0]        rsp_flags;
  logic              rsp_illegal, busy;
  logic [15:0]       op_count;
  alu_state_e        dbg_state;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- partner ALU model ----------------
  logic [32:0]       add_w, sub_w;
  logic [DATA_W-1:0] nxt_res;
  logic              nxt_c, nxt_v;

  assign add_w = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_w = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    nxt_res = '0;
    nxt_c   = alu_carry;
    nxt_v   = alu_overflow;
    case (alu_op)
      ALU_ADD: begin
        nxt_res = add_w[31:0];
        nxt_c   = add_w[32];
        nxt_v   = (alu_a[31] == alu_b[31]) && (add_w[31] != alu_a[31]);
      end
      ALU_SUB: begin
        nxt_res = sub_w[31:0];
        nxt_c   = sub_w[32];
        nxt_v   = (alu_a[31] != alu_b[31]) && (sub_w[31] != alu_a[31]);
      end
      ALU_AND: nxt_res = alu_a & alu_b;
      ALU_OR:  nxt_res = alu_a | alu_b;
      ALU_XOR: nxt_res = alu_a ^ alu_b;
      ALU_NOR: nxt_res = ~(alu_a | alu_b);
      ALU_SLT: nxt_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLL: nxt_res = alu_a << alu_b[4:0];
      ALU_SRL: nxt_res = alu_a >> alu_b[4:0];
      default: nxt_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result   <= '0;
      alu_carry    <= 1'b0;
      alu_overflow <= 1'b0;
      alu_zero     <= 1'b0;
      alu_negative <= 1'b0;
    end else begin
      alu_result   <= nxt_res;
      alu_carry    <= nxt_c;
      alu_overflow <= nxt_v;
      alu_zero     <= (alu_result == '0);
      alu_negative <= alu_result[31];
    end
  end

  // ---------------- scoreboard ----------------
  int                checks = 0;
  int                errors = 0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [EXP_W-1:0]  mon_exp;
  logic [15:0]       exp_count = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] ref_exec(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [3:0] tag);
    logic [31:0] r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0;
    if (op > 4'h8) return {tag, 1'b1, 4'b0000, 32'h0};
    case (op)
      4'h0: begin r = a + b; c = (r < a); v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h1: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {tag, 1'b0, r[31], v, c, (r == 32'h0), r};
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_result), 64'hDEAD_0000_0000_0000);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp_payload", 64'({rsp_tag, rsp_illegal, rsp_flags, rsp_result}), 64'(mon_exp));
        exp_count = exp_count + 16'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [EXP_W-1:0] exp);
    int guard = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 50) break;
    end
    if (guard > 50) begin
      chk("req_accept_timeout", 64'(guard), 64'd0);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(exp);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input int exp_lat, input string name);
    int lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      if (lat > 20) break;
    end
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  task automatic complete(input bit rand_bp);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) break;
      guard++;
      if (guard > 60) break;
      @(posedge clk);
      #1 rsp_ready = (rand_bp && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (guard > 60) chk("rsp_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [3:0]  flg;   // {N,V,C,Z}
    logic        ill;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  bit   saw_valid;

  initial begin
    vecs[0]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h1,        4'h0, 32'h0,        4'b0011, 1'b0, 3};
    vecs[1]  = '{ALU_SUB, 32'h8000_0000, 32'h1,        4'h1, 32'h7FFF_FFFF, 4'b0100, 1'b0, 3};
    vecs[2]  = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 4'h2, 32'h0,        4'b0111, 1'b0, 3};
    vecs[3]  = '{ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'h3, 32'h0000_00F0, 4'b0000, 1'b0, 3};
    vecs[4]  = '{ALU_SLT, 32'hFFFF_FFFB, 32'h3,        4'h4, 32'h1,        4'b0000, 1'b0, 3};
    vecs[5]  = '{4'hC,    32'h1234_5678, 32'h9,        4'h5, 32'h0,        4'b0000, 1'b1, 1};
    vecs[6]  = '{ALU_SRL, 32'h8000_0000, 32'd31,       4'h6, 32'h1,        4'b0000, 1'b0, 3};
    vecs[7]  = '{ALU_SUB, 32'd3,         32'd5,        4'h7, 32'hFFFF_FFFE, 4'b1010, 1'b0, 3};
    vecs[8]  = '{ALU_OR,  32'h0,         32'h0,        4'h8, 32'h0,        4'b0001, 1'b0, 3};
    vecs[9]  = '{ALU_SLL, 32'h1,         32'd4,        4'h9, 32'h10,       4'b0000, 1'b0, 3};
    vecs[10] = '{ALU_XOR, 32'hFFFF_FFFF, 32'h0,        4'hA, 32'hFFFF_FFFF, 4'b1000, 1'b0, 3};
    vecs[11] = '{ALU_ADD, 32'h7FFF_FFFF, 32'h1,        4'hB, 32'h8000_0000, 4'b1100, 1'b0, 3};
    vecs[12] = '{4'hF,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hC, 32'h0,        4'b0000, 1'b1, 1};

    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_rsp", 64'({rsp_valid, rsp_illegal, rsp_flags, rsp_tag, rsp_result}), 64'd0);
    chk("rst_alu", 64'({alu_op, alu_a, busy}), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors; the ADD->AND and SUB->OR pairs check stale C/V masking.
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
           {vecs[i].tag, vecs[i].ill, vecs[i].flg, vecs[i].res});
      if (!vecs[i].ill) begin
        chk("alu_op_drive", 64'(alu_op), 64'(vecs[i].op));
        chk("alu_ab_drive", {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
      end
      wait_valid(vecs[i].lat, "rsp_latency");
      @(posedge clk); #1;
    end
    chk("op_count_table", 64'(op_count), 64'(NV));

    // Backpressure in RESP, then accept in the cycle rsp_ready rises.
    rsp_ready = 1'b0;
    send(ALU_ADD, 32'd5, 32'd7, 4'h3, {4'h3, 1'b0, 4'b0000, 32'd12});
    wait_valid(3, "stall_latency");
    req_valid = 1'b1; req_op = ALU_SUB; req_a = 32'd10; req_b = 32'd4; req_tag = 4'h9;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 64'({rsp_valid, rsp_tag, rsp_flags, rsp_result}), {27'd0, 1'b1, 4'h3, 4'b0000, 32'd12});
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back({4'h9, 1'b0, 4'b0000, 32'd6});
    #1 req_valid = 1'b0;
    chk("b2b_op_count", 64'(op_count), 64'(NV + 1));
    chk("b2b_state", 64'(dbg_state), 64'(ST_ISSUE));
    wait_valid(3, "b2b_latency");
    @(posedge clk); #1;

    // Reset while waiting on the ALU result.
    send(ALU_ADD, 32'd1, 32'd2, 4'h5, {4'h5, 1'b0, 4'b0000, 32'd3});
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_CAP_R));
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 64'({rsp_valid, busy, op_count}), 64'd0);
    exp_q.delete();
    exp_count = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("no_rsp_after_rst", 64'(saw_valid), 64'd0);
    @(posedge clk); #1;
    send(ALU_SUB, 32'd100, 32'd1, 4'h6, {4'h6, 1'b0, 4'b0000, 32'd99});
    wait_valid(3, "post_rst_latency");
    @(posedge clk); #1;
    chk("post_rst_count", 64'(op_count), 64'd1);

    // Random ops with random response backpressure.
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 11));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) b = a;
      rsp_ready = 1'($urandom_range(0, 1));
      send(op, a, b, 4'(i), ref_exec(op, a, b, 4'(i)));
      complete(1'b1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("op_count_final", 64'(op_count), 64'(exp_count));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
